// File: rtl/ltssm_pkg.sv
// ltssm_pkg: shared training-sequence constants, receiver states and the TS field record
package ltssm_pkg;
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] TS1_ID  = 8'h4A;
    localparam logic [7:0] TS2_ID  = 8'h45;
    localparam int         TS_LEN  = 16;

    typedef enum logic [1:0] {RX_HUNT, RX_HDR, RX_ID} ts_rx_st_e;
    typedef enum logic {TS1, TS2} ts_type_e;

    typedef struct packed {
        ts_type_e   ts_type;
        logic [7:0] link_num;
        logic       link_pad;
        logic [7:0] lane_num;
        logic       lane_pad;
        logic [7:0] n_fts;
        logic [7:0] rate_id;
        logic [7:0] train_ctrl;
    } ts_fields_t;
endpackage

// File: rtl/rx_ts_if.sv
// rx_ts_if: decoded lane symbol stream in, parsed training-set report out
interface rx_ts_if;
    logic       sym_valid_i;
    logic [7:0] sym_data_i;
    logic       sym_is_k_i;
    logic       sym_err_i;
    logic       cnt_clear_i;
    logic       ts_valid_o;
    logic       ts_type_o;
    logic [7:0] link_num_o;
    logic       link_pad_o;
    logic [7:0] lane_num_o;
    logic       lane_pad_o;
    logic [7:0] n_fts_o;
    logic [7:0] rate_id_o;
    logic [7:0] train_ctrl_o;
    logic       malformed_o;
    logic [3:0] consec_cnt_o;
    logic       consec_met_o;

    modport master (
        output sym_valid_i, sym_data_i, sym_is_k_i, sym_err_i, cnt_clear_i,
        input  ts_valid_o, ts_type_o, link_num_o, link_pad_o, lane_num_o, lane_pad_o,
               n_fts_o, rate_id_o, train_ctrl_o, malformed_o, consec_cnt_o, consec_met_o
    );
    modport slave (
        input  sym_valid_i, sym_data_i, sym_is_k_i, sym_err_i, cnt_clear_i,
        output ts_valid_o, ts_type_o, link_num_o, link_pad_o, lane_num_o, lane_pad_o,
               n_fts_o, rate_id_o, train_ctrl_o, malformed_o, consec_cnt_o, consec_met_o
    );
endinterface

// File: rtl/rx_ts_receiver.sv
// rx_ts_receiver: frames TS1/TS2 ordered sets from lane symbols and counts consecutive identical sets
module rx_ts_receiver
    import ltssm_pkg::*;
#(
    parameter int CONSEC_TARGET = 8
) (
    input logic    clk_i,
    input logic    rst_i,
    rx_ts_if.slave bus
);
    localparam logic [3:0] LAST_IDX = 4'(TS_LEN - 1);

    ts_rx_st_e  st, st_n;
    logic [3:0] idx, idx_n;
    ts_fields_t cur, cur_n, prev;
    logic [3:0] cnt;
    logic       ts_valid, malformed, fail, done;
    logic       is_k, is_com, is_pad;
    logic [7:0] dat, id_byte;

    assign dat     = bus.sym_data_i;
    assign is_k    = bus.sym_is_k_i;
    assign is_com  = is_k && dat == SYM_COM && !bus.sym_err_i;
    assign is_pad  = is_k && dat == SYM_PAD;
    assign id_byte = cur.ts_type == TS2 ? TS2_ID : TS1_ID;
    assign done    = bus.sym_valid_i && st == RX_ID && idx == LAST_IDX && !fail;

    always_ff @(posedge clk_i) begin
        if (rst_i) st <= RX_HUNT;
        else st <= st_n;
    end

    always_comb begin
        st_n  = st;
        idx_n = idx;
        cur_n = cur;
        fail  = 1'b0;
        if (bus.sym_valid_i && st == RX_HUNT) begin
            st_n  = is_com ? RX_HDR : RX_HUNT;
            idx_n = 4'd1;
        end else if (bus.sym_valid_i) begin
            idx_n = idx + 4'd1;
            case (idx)
                4'd1: begin
                    cur_n.link_num = dat;
                    cur_n.link_pad = is_pad;
                    fail = is_k && !is_pad;
                end
                4'd2: begin
                    cur_n.lane_num = dat;
                    cur_n.lane_pad = is_pad;
                    fail = is_k && !is_pad;
                end
                4'd3: begin
                    cur_n.n_fts = dat;
                    fail = is_k;
                end
                4'd4: begin
                    cur_n.rate_id = dat;
                    fail = is_k;
                end
                4'd5: begin
                    cur_n.train_ctrl = dat;
                    fail = is_k;
                end
                4'd6: begin
                    cur_n.ts_type = dat == TS2_ID ? TS2 : TS1;
                    fail = is_k || (dat != TS1_ID && dat != TS2_ID);
                end
                default: fail = is_k || dat != id_byte;
            endcase
            fail = fail || bus.sym_err_i;
            st_n = idx == 4'd5 ? RX_ID : idx == LAST_IDX ? RX_HUNT : st;
            // A COM that breaks a set immediately starts the next one
            if (fail) begin
                st_n  = is_com ? RX_HDR : RX_HUNT;
                idx_n = 4'd1;
            end
        end
    end

    // prev doubles as the held field outputs: both change only on completion
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx       <= 4'd0;
            cur       <= '0;
            prev      <= '0;
            cnt       <= 4'd0;
            ts_valid  <= 1'b0;
            malformed <= 1'b0;
        end else begin
            idx       <= idx_n;
            cur       <= cur_n;
            ts_valid  <= done;
            malformed <= fail;
            if (done) begin
                prev <= cur_n;
                cnt  <= (bus.cnt_clear_i || cnt == 4'd0 || cur_n != prev) ? 4'd1 : cnt + {3'd0, cnt != 4'd15};
            end else if (fail || bus.cnt_clear_i) begin
                cnt <= 4'd0;
            end
        end
    end

    assign bus.ts_valid_o   = ts_valid;
    assign bus.malformed_o  = malformed;
    assign bus.ts_type_o    = prev.ts_type;
    assign bus.link_num_o   = prev.link_num;
    assign bus.link_pad_o   = prev.link_pad;
    assign bus.lane_num_o   = prev.lane_num;
    assign bus.lane_pad_o   = prev.lane_pad;
    assign bus.n_fts_o      = prev.n_fts;
    assign bus.rate_id_o    = prev.rate_id;
    assign bus.train_ctrl_o = prev.train_ctrl;
    assign bus.consec_cnt_o = cnt;
    assign bus.consec_met_o = cnt >= 4'(CONSEC_TARGET);
endmodule

// File: tb/tb_rx_ts_receiver.sv
// tb_rx_ts_receiver: directed and randomized symbol streams checked against a set-level reference model
module tb_rx_ts_receiver;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    rx_ts_if bus();
    rx_ts_receiver #(.CONSEC_TARGET(8)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    int n_vec = 0, n_bad = 0, pulses = 0;
    bit chk = 0;

    bit          in_set;
    int          pos;
    logic [7:0]  rec[16];
    bit          kf[16];
    int          e_cnt;
    bit          e_valid, e_mal;
    logic [42:0] e_f;

    task automatic cmp(input string nm, input logic [7:0] a, input logic [7:0] x);
        n_vec++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
        end
    endtask

    function automatic bit sym_ok(int p, bit k, logic [7:0] d);
        if (p <= 2) return !k || d == 8'hF7;
        if (p <= 5) return !k;
        if (p == 6) return !k && (d == 8'h4A || d == 8'h45);
        return !k && d == rec[6];
    endfunction

    // Collects the accepted symbols of a set and decodes them only when all 16 are in
    task automatic model(bit r, bit v, logic [7:0] d, bit k, bit e, bit clr);
        logic [42:0] nf;
        bit is_com;
        is_com  = k && d == 8'hBC && !e;
        e_valid = 0;
        e_mal   = 0;
        if (r) begin
            in_set = 0; pos = 0; e_cnt = 0; e_f = '0;
            return;
        end
        if (clr) e_cnt = 0;
        if (!v) return;
        if (!in_set) begin
            in_set = is_com; pos = 1;
            return;
        end
        if (e || !sym_ok(pos, k, d)) begin
            e_mal = 1; e_cnt = 0; in_set = is_com; pos = 1;
            return;
        end
        rec[pos] = d;
        kf[pos]  = k;
        if (pos < 15) begin
            pos++;
            return;
        end
        nf = {rec[6] == 8'h45, rec[1], kf[1], rec[2], kf[2], rec[3], rec[4], rec[5]};
        e_cnt   = (e_cnt != 0 && nf == e_f) ? (e_cnt == 15 ? 15 : e_cnt + 1) : 1;
        e_f     = nf;
        e_valid = 1;
        in_set  = 0;
    endtask

    task automatic tick(bit v, logic [7:0] d, bit k, bit e, bit clr, bit r);
        rst_i           = r;
        bus.sym_valid_i = v;
        bus.sym_data_i  = d;
        bus.sym_is_k_i  = k;
        bus.sym_err_i   = e;
        bus.cnt_clear_i = clr;
        @(posedge clk_i);
        model(r, v, d, k, e, clr);
        chk = 1;
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick(0, 8'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    endtask

    task automatic send_set(bit t, logic [7:0] link, bit lp, logic [7:0] lane, bit lnp,
                            logic [7:0] nfts, logic [7:0] rate, logic [7:0] ctrl,
                            int err_idx, int gap_idx, int gap_len, bit clr_last, bit rnd);
        logic [7:0] d[16];
        bit         k[16];
        int         c;
        d[0] = 8'hBC;               k[0] = 1;
        d[1] = lp ? 8'hF7 : link;   k[1] = lp;
        d[2] = lnp ? 8'hF7 : lane;  k[2] = lnp;
        d[3] = nfts;                k[3] = 0;
        d[4] = rate;                k[4] = 0;
        d[5] = ctrl;                k[5] = 0;
        for (int i = 6; i < 16; i++) begin
            d[i] = t ? 8'h45 : 8'h4A;
            k[i] = 0;
        end
        if (rnd && $urandom_range(0, 5) == 0) begin
            c = $urandom_range(1, 15);
            if ($urandom_range(0, 1) == 1) k[c] = ~k[c];
            else d[c] = d[c] ^ 8'($urandom_range(1, 255));
        end
        for (int i = 0; i < 16; i++) begin
            if (i == gap_idx) idle(gap_len);
            if (rnd) while ($urandom_range(0, 4) == 0) idle(1);
            tick(1, d[i], k[i], i == err_idx || (rnd && $urandom_range(0, 60) == 0),
                 (clr_last && i == 15) || (rnd && $urandom_range(0, 50) == 0), 0);
        end
    endtask

    task automatic ts1_std(int err_idx, int gap_idx, bit clr_last);
        send_set(0, 8'h00, 1, 8'h00, 1, 8'h20, 8'h02, 8'h00, err_idx, gap_idx, 5, clr_last, 0);
    endtask

    always @(negedge clk_i) begin
        if (chk) begin
            cmp("ts_valid", 8'(bus.ts_valid_o), 8'(e_valid));
            cmp("malformed", 8'(bus.malformed_o), 8'(e_mal));
            cmp("consec_cnt", 8'(bus.consec_cnt_o), 8'(e_cnt));
            cmp("consec_met", 8'(bus.consec_met_o), 8'(e_cnt >= 8));
            cmp("ts_type", 8'(bus.ts_type_o), 8'(e_f[42]));
            cmp("link_num", bus.link_num_o, e_f[41:34]);
            cmp("link_pad", 8'(bus.link_pad_o), 8'(e_f[33]));
            cmp("lane_num", bus.lane_num_o, e_f[32:25]);
            cmp("lane_pad", 8'(bus.lane_pad_o), 8'(e_f[24]));
            cmp("n_fts", bus.n_fts_o, e_f[23:16]);
            cmp("rate_id", bus.rate_id_o, e_f[15:8]);
            cmp("train_ctrl", bus.train_ctrl_o, e_f[7:0]);
            if (bus.ts_valid_o) pulses++;
        end
    end

    initial begin
        logic [7:0] f_link, f_lane, f_nfts, f_rate, f_ctrl;
        bit f_t, f_lp, f_lnp;
        bus.sym_valid_i = 0; bus.sym_data_i = 0; bus.sym_is_k_i = 0;
        bus.sym_err_i = 0; bus.cnt_clear_i = 0;
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        cmp("lit_reset_cnt", 8'(bus.consec_cnt_o), 8'd0);
        pulses = 0;

        repeat (8) ts1_std(-1, -1, 0);
        idle(1);
        cmp("lit_pulses8", 8'(pulses), 8'd8);
        cmp("lit_cnt8", 8'(bus.consec_cnt_o), 8'd8);
        cmp("lit_met8", 8'(bus.consec_met_o), 8'd1);
        cmp("lit_link_pad", 8'(bus.link_pad_o), 8'd1);
        cmp("lit_lane_pad", 8'(bus.lane_pad_o), 8'd1);

        repeat (3) ts1_std(-1, -1, 0);
        send_set(1, 8'h05, 0, 8'h00, 0, 8'h20, 8'h02, 8'h00, -1, -1, 0, 0, 0);
        cmp("lit_ts2_type", 8'(bus.ts_type_o), 8'd1);
        cmp("lit_ts2_link", bus.link_num_o, 8'h05);
        cmp("lit_ts2_cnt", 8'(bus.consec_cnt_o), 8'd1);

        ts1_std(9, -1, 0);
        idle(1);
        cmp("lit_err_cnt", 8'(bus.consec_cnt_o), 8'd0);
        ts1_std(-1, -1, 0);
        cmp("lit_after_err_cnt", 8'(bus.consec_cnt_o), 8'd1);

        tick(1, 8'hBC, 1, 0, 0, 0);
        tick(1, 8'hF7, 1, 0, 0, 0);
        tick(1, 8'hF7, 1, 0, 0, 0);
        tick(1, 8'h20, 0, 0, 0, 0);
        ts1_std(-1, -1, 0);
        cmp("lit_realign_cnt", 8'(bus.consec_cnt_o), 8'd1);

        repeat (20) ts1_std(-1, 11, 0);
        cmp("lit_sat_cnt", 8'(bus.consec_cnt_o), 8'd15);

        tick(0, 0, 0, 0, 1, 0);
        repeat (6) ts1_std(-1, -1, 0);
        cmp("lit_cnt6", 8'(bus.consec_cnt_o), 8'd6);
        ts1_std(-1, -1, 1);
        cmp("lit_clr_done_cnt", 8'(bus.consec_cnt_o), 8'd1);
        ts1_std(-1, -1, 0);
        cmp("lit_after_clr_cnt", 8'(bus.consec_cnt_o), 8'd2);

        tick(1, 8'hBC, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(1, 8'h4A, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        cmp("lit_midreset_cnt", 8'(bus.consec_cnt_o), 8'd0);

        f_t = 0; f_link = 8'h01; f_lp = 0; f_lane = 8'h02; f_lnp = 0;
        f_nfts = 8'h10; f_rate = 8'h02; f_ctrl = 8'h00;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                f_t = 1'($urandom); f_link = 8'($urandom); f_lp = 1'($urandom);
                f_lane = 8'($urandom); f_lnp = 1'($urandom); f_nfts = 8'($urandom);
                f_rate = 8'($urandom); f_ctrl = 8'($urandom);
            end
            repeat ($urandom_range(0, 2))
                tick(1, ($urandom_range(0, 7) == 0) ? 8'hBC : 8'($urandom),
                     $urandom_range(0, 2) == 0, 0, 0, 0);
            send_set(f_t, f_link, f_lp, f_lane, f_lnp, f_nfts, f_rate, f_ctrl, -1, -1, 0, 0, 1);
        end
        idle(3);
        chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
